// File: rtl/fetch_if.sv
// Instruction-memory read port: request/address out, acknowledge/data back.
// The master side is the fetch stage; the slave side is the memory.
interface fetch_if;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          req;
    logic [AW-1:0] addr;
    logic          ack;
    logic [DW-1:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch.sv
// MIPS instruction-fetch stage: owns the fetch PC, reads instruction memory over
// a req/ack port and loads the IF/ID register, honouring stalls and redirects.
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_con_stall,
    input  logic        i_con_ifbranch,
    input  logic [31:0] i_addr_pcadd,
    input  logic        i_con_jump,
    input  logic [31:0] i_addr_jump,
    fetch_if.master     imem,
    output logic [31:0] o_addr_pc4,
    output logic [31:0] o_data_instr,
    output logic        o_valid
);
    localparam int unsigned AW = 32;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_KILL  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          req_q, req_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] tgt_q, tgt_d;
    logic [AW-1:0] buf_pc4_q, buf_pc4_d;
    logic [AW-1:0] buf_instr_q, buf_instr_d;
    logic [AW-1:0] pc4_q, pc4_d;
    logic [AW-1:0] instr_q, instr_d;
    logic          valid_q, valid_d;

    logic          ack;
    logic          redirect;
    logic [AW-1:0] pc_plus4;
    logic [AW-1:0] raw_target;
    logic [AW-1:0] target;

    // A response only counts while we are actually requesting.
    assign ack        = imem.ack & req_q;
    assign redirect   = valid_q & ~i_con_stall & (i_con_jump | i_con_ifbranch);
    assign pc_plus4   = pc_q + AW'(4);
    assign raw_target = i_con_jump ? i_addr_jump : i_addr_pcadd;
    assign target     = {raw_target[AW-1:2], 2'b00};

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        tgt_d       = tgt_q;
        buf_pc4_d   = buf_pc4_q;
        buf_instr_d = buf_instr_q;
        pc4_d       = pc4_q;
        instr_d     = instr_q;
        valid_d     = valid_q;

        unique case (state_q)
            S_FETCH: begin
                if (ack) begin
                    if (redirect) begin
                        pc_d    = target;
                        instr_d = NOP;
                        valid_d = 1'b0;
                    end else if (i_con_stall) begin
                        buf_pc4_d   = pc_plus4;
                        buf_instr_d = imem.rdata;
                        pc_d        = pc_plus4;
                        state_d     = S_HOLD;
                    end else begin
                        pc4_d   = pc_plus4;
                        instr_d = imem.rdata;
                        valid_d = 1'b1;
                        pc_d    = pc_plus4;
                    end
                end else if (redirect) begin
                    // Wrong-path read still in flight: remember where to go once it lands.
                    tgt_d   = target;
                    instr_d = NOP;
                    valid_d = 1'b0;
                    state_d = S_KILL;
                end else if (!i_con_stall) begin
                    instr_d = NOP;
                    valid_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (i_con_stall) begin
                    state_d = S_HOLD;
                end else if (redirect) begin
                    pc_d    = target;
                    instr_d = NOP;
                    valid_d = 1'b0;
                    state_d = S_FETCH;
                end else begin
                    pc4_d   = buf_pc4_q;
                    instr_d = buf_instr_q;
                    valid_d = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_KILL: begin
                if (ack) begin
                    pc_d    = tgt_q;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Request is registered so it is low throughout reset.
    assign req_d = (state_d != S_HOLD);

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q     <= S_FETCH;
            req_q       <= 1'b0;
            pc_q        <= RESET_PC;
            tgt_q       <= '0;
            buf_pc4_q   <= '0;
            buf_instr_q <= '0;
            pc4_q       <= '0;
            instr_q     <= NOP;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            pc_q        <= pc_d;
            tgt_q       <= tgt_d;
            buf_pc4_q   <= buf_pc4_d;
            buf_instr_q <= buf_instr_d;
            pc4_q       <= pc4_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
        end
    end

    assign imem.req     = req_q;
    assign imem.addr    = pc_q;
    assign o_addr_pc4   = pc4_q;
    assign o_data_instr = instr_q;
    assign o_valid      = valid_q;
endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: memory returns word index (mem[i]=i); a
// scoreboard checks every instruction decode consumes (valid and not stalled).
module tb_fetch;
    logic        i_clk;
    logic        i_nrst;
    logic        con_stall;
    logic        con_branch;
    logic [31:0] addr_pcadd;
    logic        con_jump;
    logic [31:0] addr_jump;
    logic [31:0] addr_pc4;
    logic [31:0] data_instr;
    logic        valid;

    fetch_if bus ();

    fetch #(.RESET_PC(32'h0000_0000), .NOP(32'h0000_0000)) dut (
        .i_clk          (i_clk),
        .i_nrst         (i_nrst),
        .i_con_stall    (con_stall),
        .i_con_ifbranch (con_branch),
        .i_addr_pcadd   (addr_pcadd),
        .i_con_jump     (con_jump),
        .i_addr_jump    (addr_jump),
        .imem           (bus.master),
        .o_addr_pc4     (addr_pc4),
        .o_data_instr   (data_instr),
        .o_valid        (valid)
    );

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    assign bus.rdata = bus.addr >> 2;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic void push(input logic [31:0] a);
        sb.push_back({a + 32'd4, a >> 2});
    endfunction

    // Inputs apply to the coming edge; returns 2 time units after it.
    task automatic drive(input logic ack, input logic stall, input logic jmp, input logic br);
        bus.ack    = ack;
        con_stall  = stall;
        con_jump   = jmp;
        con_branch = br;
        @(posedge i_clk);
        #2;
    endtask

    // Scoreboard: decode takes the IF/ID entry whenever it is valid and not stalled.
    always @(negedge i_clk) begin
        if (i_nrst && valid && !con_stall) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got pc4=%h instr=%h, none expected", addr_pc4, data_instr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (addr_pc4 !== e.pc4 || data_instr !== e.instr) begin
                    n_err++;
                    $display("FAIL sb_ifid: got pc4=%h instr=%h want pc4=%h instr=%h",
                             addr_pc4, data_instr, e.pc4, e.instr);
                end
            end
        end
    end

    task automatic test_reset();
        repeat (2) @(posedge i_clk);
        #2;
        n_cmp++;
        if (bus.req !== 1'b0 || valid !== 1'b0 || data_instr !== 32'h0 || addr_pc4 !== 32'h0) begin
            n_err++;
            $display("FAIL reset_state: req=%b valid=%b instr=%h pc4=%h want 0/0/0/0",
                     bus.req, valid, data_instr, addr_pc4);
        end
        i_nrst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.req !== 1'b1 || bus.addr !== 32'h0) begin
            n_err++;
            $display("FAIL first_req: req=%b addr=%h want 1/00000000", bus.req, bus.addr);
        end
    endtask

    task automatic test_zero_wait();
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            a = 32'(4 * i);
            n_cmp++;
            if (bus.req !== 1'b1 || bus.addr !== a) begin
                n_err++;
                $display("FAIL zw_addr: req=%b addr=%h want 1/%h", bus.req, bus.addr, a);
            end
            if (i == 1) begin
                n_cmp++;
                if (valid !== 1'b1 || addr_pc4 !== 32'h4) begin
                    n_err++;
                    $display("FAIL zw_first_valid: valid=%b pc4=%h want 1/00000004", valid, addr_pc4);
                end
            end
            push(a);
            drive(1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_wait_states();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (valid !== 1'b0 || bus.req !== 1'b1 || bus.addr !== 32'hC) begin
                n_err++;
                $display("FAIL ws_wait: valid=%b req=%b addr=%h want 0/1/0000000c", valid, bus.req, bus.addr);
            end
        end
        push(32'hC);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (valid !== 1'b1 || addr_pc4 !== 32'h10) begin
            n_err++;
            $display("FAIL ws_valid: valid=%b pc4=%h want 1/00000010", valid, addr_pc4);
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (bus.req !== 1'b0 || valid !== 1'b1 || addr_pc4 !== 32'h10 || data_instr !== 32'h3) begin
                n_err++;
                $display("FAIL stall_hold: req=%b valid=%b pc4=%h instr=%h want 0/1/00000010/00000003",
                         bus.req, valid, addr_pc4, data_instr);
            end
            if (i < 3) drive(1'b0, 1'b1, 1'b0, 1'b0);
        end
        push(32'h10);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (valid !== 1'b1 || addr_pc4 !== 32'h14 || data_instr !== 32'h4 ||
            bus.req !== 1'b1 || bus.addr !== 32'h14) begin
            n_err++;
            $display("FAIL stall_release: valid=%b pc4=%h instr=%h req=%b addr=%h want 1/14/4/1/14",
                     valid, addr_pc4, data_instr, bus.req, bus.addr);
        end
    endtask

    task automatic test_jump();
        for (int i = 0; i < 3; i++) begin
            push(32'h14 + 32'(4 * i));
            drive(1'b1, 1'b0, 1'b0, 1'b0);
        end
        n_cmp++;
        if (bus.addr !== 32'h20) begin
            n_err++;
            $display("FAIL jump_pre: addr=%h want 00000020", bus.addr);
        end
        addr_jump = 32'h0000_0402;
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (valid !== 1'b0 || data_instr !== 32'h0 || bus.req !== 1'b1 || bus.addr !== 32'h400) begin
            n_err++;
            $display("FAIL jump_squash: valid=%b instr=%h req=%b addr=%h want 0/0/1/00000400",
                     valid, data_instr, bus.req, bus.addr);
        end
        push(32'h400);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_branch_kill();
        addr_pcadd = 32'h0000_0080;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (bus.req !== 1'b1 || bus.addr !== 32'h404 || valid !== 1'b0) begin
                n_err++;
                $display("FAIL kill_wait: req=%b addr=%h valid=%b want 1/00000404/0", bus.req, bus.addr, valid);
            end
            if (i < 2) drive(1'b0, (i == 0), 1'b0, 1'b0);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.req !== 1'b1 || bus.addr !== 32'h80 || valid !== 1'b0) begin
            n_err++;
            $display("FAIL kill_redirect: req=%b addr=%h valid=%b want 1/00000080/0", bus.req, bus.addr, valid);
        end
    endtask

    task automatic test_jump_and_branch();
        push(32'h80);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        addr_jump  = 32'h0000_0200;
        addr_pcadd = 32'h0000_0300;
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (bus.addr !== 32'h200 || valid !== 1'b0) begin
            n_err++;
            $display("FAIL jump_wins: addr=%h valid=%b want 00000200/0", bus.addr, valid);
        end
    endtask

    task automatic test_wrap();
        push(32'h200);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        addr_jump = 32'hFFFF_FFFC;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.addr !== 32'hFFFF_FFFC) begin
            n_err++;
            $display("FAIL wrap_target: addr=%h want fffffffc", bus.addr);
        end
        push(32'hFFFF_FFFC);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (valid !== 1'b1 || addr_pc4 !== 32'h0 || bus.addr !== 32'h0) begin
            n_err++;
            $display("FAIL wrap_pc4: valid=%b pc4=%h addr=%h want 1/00000000/00000000", valid, addr_pc4, bus.addr);
        end
        push(32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        bus.ack = 1'b1;
        i_nrst  = 1'b0;
        #1;
        n_cmp++;
        if (bus.req !== 1'b0 || valid !== 1'b0 || data_instr !== 32'h0 || addr_pc4 !== 32'h0) begin
            n_err++;
            $display("FAIL rst_mid: req=%b valid=%b instr=%h pc4=%h want 0/0/0/0", bus.req, valid, data_instr, addr_pc4);
        end
        @(posedge i_clk);
        #2;
        i_nrst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.req !== 1'b1 || bus.addr !== 32'h0 || valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_restart: req=%b addr=%h valid=%b want 1/00000000/0", bus.req, bus.addr, valid);
        end
        push(32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d entries left want 0", sb.size());
        end
    endtask

    initial begin
        i_nrst     = 1'b0;
        con_stall  = 1'b0;
        con_branch = 1'b0;
        con_jump   = 1'b0;
        addr_pcadd = 32'h0;
        addr_jump  = 32'h0;
        bus.ack    = 1'b0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_jump();
        test_branch_kill();
        test_jump_and_branch();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
